// File: rtl/spi_flash_pkg.sv
// ----------------------------------------------------------------------------
// spi_flash_pkg
// Shared types and constants for the SPI flash read responder.
//   flash_state_t : responder FSM states (IDLE, SHIFT, DONE)
//   CMD_READ      : serial flash READ opcode
//   TX_BITS       : opcode + 24-bit address bits driven on MOSI
//   TOTAL_BITS    : full transaction length in SCK periods (TX + 8 RX bits)
// ----------------------------------------------------------------------------
package spi_flash_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } flash_state_t;

   localparam logic [7:0] CMD_READ   = 8'h03;
   localparam int         TX_BITS    = 32;
   localparam int         TOTAL_BITS = 40;

endpackage

// File: rtl/spi_flash_shifter.sv
// ----------------------------------------------------------------------------
// spi_flash_shifter
// Serial engine for one SPI mode-0 READ transaction: SCK divider, bit counter,
// TX/RX shift registers and MOSI/MISO timing. All pin outputs are registered.
// Parameters:
//   CLK_DIV : SCK half-period in clk cycles (minimum 1, 0 is illegal)
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous reset, active-low (aborts any transfer)
//   start     in   load tx_word and begin a transfer (ignored while busy)
//   tx_word   in   32-bit {opcode, address}, sent MSB first
//   miso      in   flash serial data out
//   done      out  asserted in the cycle the last SCK high phase ends
//   rx_byte   out  byte assembled from the last 8 SCK periods
//   spi_cs_n  out  flash chip select, active-low
//   spi_sck   out  SPI clock, idles low
//   spi_mosi  out  SPI data to flash
// ----------------------------------------------------------------------------
module spi_flash_shifter
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] tx_word,
   input  logic        miso,
   output logic        done,
   output logic [7:0]  rx_byte,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic             busy;
   logic [DIV_W-1:0] div_cnt;
   logic [5:0]       bit_cnt;
   logic [31:0]      tx_sr;
   logic [7:0]       rx_sr;
   logic             half_end;
   logic             last_fall;

   // A half period ends when the divider has spent CLK_DIV cycles in the
   // current SCK level. The final falling edge of period 40 is where the
   // transfer finishes, so done is flagged on that same clk edge.
   assign half_end  = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign last_fall = half_end && spi_sck && (bit_cnt == 6'(TOTAL_BITS - 1));
   assign done      = last_fall;
   assign rx_byte   = rx_sr;

   // bit_cnt counts completed SCK periods. MOSI only moves on the falling
   // transition (SCK low afterwards); MISO is captured on the transition to
   // high, and only once the 32 TX periods are over. tx_sr pre-shifts the
   // word so zeros naturally fill MOSI during the RX periods.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy     <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         spi_cs_n <= 1'b1;
         spi_sck  <= 1'b0;
         spi_mosi <= 1'b0;
      end else if (start && !busy) begin
         busy     <= 1'b1;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_sr    <= {tx_word[30:0], 1'b0};
         rx_sr    <= '0;
         spi_cs_n <= 1'b0;
         spi_sck  <= 1'b0;
         spi_mosi <= tx_word[31];
      end else if (busy) begin
         if (half_end) begin
            div_cnt <= '0;
            if (!spi_sck) begin
               spi_sck <= 1'b1;
               if (bit_cnt >= 6'(TX_BITS)) begin
                  rx_sr <= {rx_sr[6:0], miso};
               end
            end else begin
               spi_sck <= 1'b0;
               if (last_fall) begin
                  busy     <= 1'b0;
                  spi_cs_n <= 1'b1;
                  spi_mosi <= 1'b0;
               end else begin
                  bit_cnt  <= bit_cnt + 6'd1;
                  spi_mosi <= tx_sr[31];
                  tx_sr    <= {tx_sr[30:0], 1'b0};
               end
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/spi_flash_reader.sv
// ----------------------------------------------------------------------------
// spi_flash_reader
// Responder for 6809 read cycles in the SPI flash window. A rising edge of
// (i_spi_ce & i_rw) starts a serial READ (0x03) of FLASH_BASE + i_address;
// o_mrdy is held low until the byte arrives, then o_data/o_data_valid update
// and the CPU is released.
// Optional feature macro: SPI_FLASH_CACHE_EN -- single-entry read cache that
// answers a repeated address directly without any SPI activity.
// Parameters:
//   CLK_DIV    : SCK half-period in i_clk cycles (minimum 1)
//   FLASH_BASE : flash byte address mapped to CPU offset 0
// Ports:
//   i_clk         in   system clock
//   i_reset       in   synchronous reset, active-low
//   i_spi_ce      in   flash window select from the address decoder
//   i_rw          in   CPU R/W, 1 = read
//   i_address     in   CPU address offset within the window [11:0]
//   i_spi_miso    in   flash serial data out
//   o_data        out  last byte read
//   o_data_valid  out  one-cycle pulse when o_data updates
//   o_mrdy        out  CPU memory ready, 0 stretches the bus cycle
//   o_spi_cs_n    out  flash chip select, active-low
//   o_spi_sck     out  SPI clock, mode 0
//   o_spi_mosi    out  SPI data to flash
// ----------------------------------------------------------------------------
module spi_flash_reader
   import spi_flash_pkg::*;
#(
   parameter int          CLK_DIV    = 2,
   parameter logic [23:0] FLASH_BASE = 24'h000000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_spi_ce,
   input  logic        i_rw,
   input  logic [11:0] i_address,
   input  logic        i_spi_miso,
   output logic [7:0]  o_data,
   output logic        o_data_valid,
   output logic        o_mrdy,
   output logic        o_spi_cs_n,
   output logic        o_spi_sck,
   output logic        o_spi_mosi
);

   flash_state_t state;
   flash_state_t state_next;

   logic        trig_prev;
   logic        read_req;
   logic        trigger;
   logic [23:0] flash_addr;
   logic [31:0] tx_word;
   logic        start;
   logic        shift_done;
   logic [7:0]  rx_byte;
   logic        cache_hit;
   logic [7:0]  cache_byte;
   logic [7:0]  data_next;
   logic        valid_next;
   logic        mrdy_next;

   // Only a fresh read request counts; holding the select high after a
   // completed access must not launch another transfer.
   assign read_req   = i_spi_ce & i_rw;
   assign trigger    = read_req & ~trig_prev;
   assign flash_addr = FLASH_BASE + {12'h000, i_address};
   assign tx_word    = {CMD_READ, flash_addr};

   spi_flash_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk      (i_clk),
      .reset_n  (i_reset),
      .start    (start),
      .tx_word  (tx_word),
      .miso     (i_spi_miso),
      .done     (shift_done),
      .rx_byte  (rx_byte),
      .spi_cs_n (o_spi_cs_n),
      .spi_sck  (o_spi_sck),
      .spi_mosi (o_spi_mosi)
   );

`ifdef SPI_FLASH_CACHE_EN
   logic        cache_valid;
   logic [23:0] cache_addr;
   logic [7:0]  cache_data;
   logic [23:0] pend_addr;

   assign cache_hit  = cache_valid && (cache_addr == flash_addr);
   assign cache_byte = cache_data;

   // The requested address is remembered at launch so the entry can be
   // filled when the byte returns. Reset is the only way a transfer can be
   // aborted, so clearing the entry on reset also covers aborts.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         cache_valid <= 1'b0;
         cache_addr  <= '0;
         cache_data  <= '0;
         pend_addr   <= '0;
      end else begin
         if (start) begin
            pend_addr <= flash_addr;
         end
         if (state == SHIFT && shift_done) begin
            cache_valid <= 1'b1;
            cache_addr  <= pend_addr;
            cache_data  <= rx_byte;
         end
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_byte = 8'h00;
`endif

   // State, trigger history and the CPU-facing outputs are all registered
   // so nothing reaches a pin combinationally from an input.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state        <= IDLE;
         trig_prev    <= 1'b0;
         o_data       <= 8'h00;
         o_data_valid <= 1'b0;
         o_mrdy       <= 1'b1;
      end else begin
         state        <= state_next;
         trig_prev    <= read_req;
         o_data       <= data_next;
         o_data_valid <= valid_next;
         o_mrdy       <= mrdy_next;
      end
   end

   // DONE waits for the select to drop so one CPU access produces exactly
   // one transfer. A cache hit skips SHIFT and never lowers o_mrdy.
   always_comb begin
      state_next = state;
      data_next  = o_data;
      valid_next = 1'b0;
      mrdy_next  = o_mrdy;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               if (cache_hit) begin
                  state_next = DONE;
                  data_next  = cache_byte;
                  valid_next = 1'b1;
                  mrdy_next  = 1'b1;
               end else begin
                  state_next = SHIFT;
                  start      = 1'b1;
                  mrdy_next  = 1'b0;
               end
            end
         end
         SHIFT: begin
            if (shift_done) begin
               state_next = DONE;
               data_next  = rx_byte;
               valid_next = 1'b1;
               mrdy_next  = 1'b1;
            end
         end
         DONE: begin
            if (!i_spi_ce) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_flash_reader.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_reader
// Self-checking bench for spi_flash_reader. Two instances share the CPU-side
// inputs: dut0 with FLASH_BASE = 0 and dut1 with FLASH_BASE = 24'hFFFFFF for
// the address wrap case. A behavioural flash model per instance captures the
// MOSI word and answers on MISO; expected bytes go through a scoreboard queue.
// Follows SPI_FLASH_CACHE_EN for the cache expectations.
// ----------------------------------------------------------------------------
module tb_spi_flash_reader;

   localparam int TB_CLK_DIV = 2;
   localparam int EXP_STALL  = 80 * TB_CLK_DIV;

   logic        i_clk;
   logic        i_reset;
   logic        i_spi_ce;
   logic        i_rw;
   logic [11:0] i_address;
   logic [1:0]  miso_v;

   wire  [7:0]  data0;
   wire  [7:0]  data1;
   wire         valid0;
   wire         valid1;
   wire         mrdy0;
   wire         mrdy1;
   wire  [1:0]  cs_n_w;
   wire  [1:0]  sck_w;
   wire  [1:0]  mosi_w;

   logic [7:0]  resp_byte [2];
   logic [31:0] tx_cap [2];
   int          rise_cnt [2];
   logic        sck_prev [2];
   int          mosi_rx_err [2];

   logic [7:0]  exp_q [$];
   int          checks;
   int          failures;

   spi_flash_reader #(
      .CLK_DIV    (TB_CLK_DIV),
      .FLASH_BASE (24'h000000)
   ) dut0 (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_spi_ce     (i_spi_ce),
      .i_rw         (i_rw),
      .i_address    (i_address),
      .i_spi_miso   (miso_v[0]),
      .o_data       (data0),
      .o_data_valid (valid0),
      .o_mrdy       (mrdy0),
      .o_spi_cs_n   (cs_n_w[0]),
      .o_spi_sck    (sck_w[0]),
      .o_spi_mosi   (mosi_w[0])
   );

   spi_flash_reader #(
      .CLK_DIV    (TB_CLK_DIV),
      .FLASH_BASE (24'hFFFFFF)
   ) dut1 (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_spi_ce     (i_spi_ce),
      .i_rw         (i_rw),
      .i_address    (i_address),
      .i_spi_miso   (miso_v[1]),
      .o_data       (data1),
      .o_data_valid (valid1),
      .o_mrdy       (mrdy1),
      .o_spi_cs_n   (cs_n_w[1]),
      .o_spi_sck    (sck_w[1]),
      .o_spi_mosi   (mosi_w[1])
   );

   // 10 ns system clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Flash model, evaluated mid-cycle while SCK is stable. Each observed SCK
   // rise latches MOSI; the first 32 form the command word, the rest must be
   // zero. MISO presents the response bit the DUT samples on its next rise.
   initial begin
      for (int i = 0; i < 2; i++) begin
         rise_cnt[i]    = 0;
         sck_prev[i]    = 1'b0;
         tx_cap[i]      = '0;
         mosi_rx_err[i] = 0;
         resp_byte[i]   = 8'h00;
      end
      miso_v = 2'b00;
   end

   always @(negedge i_clk) begin
      for (int i = 0; i < 2; i++) begin
         if (cs_n_w[i] !== 1'b0) begin
            rise_cnt[i] = 0;
            sck_prev[i] = 1'b0;
            miso_v[i]   = 1'b0;
         end else begin
            if (sck_w[i] === 1'b1 && sck_prev[i] === 1'b0) begin
               if (rise_cnt[i] < 32) begin
                  tx_cap[i] = {tx_cap[i][30:0], mosi_w[i]};
               end else if (mosi_w[i] !== 1'b0) begin
                  mosi_rx_err[i] = mosi_rx_err[i] + 1;
               end
               rise_cnt[i] = rise_cnt[i] + 1;
            end
            sck_prev[i] = sck_w[i];
            if (rise_cnt[i] >= 32 && rise_cnt[i] < 40) begin
               miso_v[i] = resp_byte[i][39 - rise_cnt[i]];
            end else begin
               miso_v[i] = 1'b0;
            end
         end
      end
   end

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Raises a read request and waits (bounded) for o_mrdy to return.
   // Reports stall length, CS-low cycles and the first post-trigger outputs.
   task automatic run_read(input logic [11:0] addr, input logic [7:0] resp,
                           output int stall, output int cs_low,
                           output logic [2:0] first, output logic got_valid,
                           output logic [7:0] got_data);
      resp_byte[0] = resp;
      resp_byte[1] = resp;
      i_address    = addr;
      i_rw         = 1'b1;
      i_spi_ce     = 1'b1;
      tick();
      first  = {mrdy0, cs_n_w[0], mosi_w[0]};
      stall  = 0;
      cs_low = 0;
      while (mrdy0 === 1'b0 && stall < 1000) begin
         stall++;
         if (cs_n_w[0] === 1'b0) cs_low++;
         tick();
      end
      got_valid = valid0;
      got_data  = data0;
   endtask

   task automatic test_reset();
      int sck_high;
      sck_high  = 0;
      i_reset   = 1'b0;
      i_spi_ce  = 1'b0;
      i_rw      = 1'b1;
      i_address = 12'h000;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (sck_w[0] !== 1'b0) sck_high++;
      end
      checks++;
      if (cs_n_w[0] !== 1'b1) begin failures++; $display("[TB] FAIL reset_cs_n: got %b expected 1", cs_n_w[0]); end
      checks++;
      if (mosi_w[0] !== 1'b0) begin failures++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi_w[0]); end
      checks++;
      if (data0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h expected 00", data0); end
      checks++;
      if (valid0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid0); end
      checks++;
      if (mrdy0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_mrdy: got %b expected 1", mrdy0); end
      checks++;
      if (sck_high !== 0) begin failures++; $display("[TB] FAIL reset_sck_idle: got %0d high samples expected 0", sck_high); end
      i_reset = 1'b1;
      tick();
   endtask

   task automatic test_read();
      int         stall;
      int         cs_low;
      int         err0;
      logic [2:0] first;
      logic       got_valid;
      logic [7:0] got_data;
      logic [7:0] exp;
      err0 = mosi_rx_err[0];
      exp_q.push_back(8'hA5);
      run_read(12'h123, 8'hA5, stall, cs_low, first, got_valid, got_data);
      checks++;
      if (first !== 3'b000) begin failures++; $display("[TB] FAIL read_first_cycle {mrdy,cs_n,mosi}: got %b expected 000", first); end
      checks++;
      if (stall !== EXP_STALL) begin failures++; $display("[TB] FAIL read_stall: got %0d expected %0d", stall, EXP_STALL); end
      checks++;
      if (cs_low !== EXP_STALL) begin failures++; $display("[TB] FAIL read_cs_low: got %0d expected %0d", cs_low, EXP_STALL); end
      checks++;
      if (cs_n_w[0] !== 1'b1) begin failures++; $display("[TB] FAIL read_cs_release: got %b expected 1", cs_n_w[0]); end
      checks++;
      if (got_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL read_valid: got %b expected 1", got_valid);
      end else begin
         exp = exp_q.pop_front();
         if (got_data !== exp) begin failures++; $display("[TB] FAIL read_data: got %h expected %h", got_data, exp); end
      end
      checks++;
      if (tx_cap[0] !== 32'h03000123) begin failures++; $display("[TB] FAIL read_mosi_word: got %h expected 03000123", tx_cap[0]); end
      checks++;
      if (mosi_rx_err[0] !== err0) begin failures++; $display("[TB] FAIL read_mosi_rx_zero: got %0d nonzero bits expected 0", mosi_rx_err[0] - err0); end
      i_spi_ce = 1'b0;
      tick();
      checks++;
      if (valid0 !== 1'b0) begin failures++; $display("[TB] FAIL read_valid_pulse: got %b expected 0", valid0); end
      tick();
   endtask

   task automatic test_wrap();
      int         stall;
      int         cs_low;
      logic [2:0] first;
      logic       got_valid;
      logic [7:0] got_data;
      logic [7:0] exp;
      exp_q.push_back(8'hC3);
      run_read(12'h002, 8'hC3, stall, cs_low, first, got_valid, got_data);
      checks++;
      if (tx_cap[1] !== 32'h03000001) begin failures++; $display("[TB] FAIL wrap_mosi_word: got %h expected 03000001", tx_cap[1]); end
      checks++;
      if (tx_cap[0] !== 32'h03000002) begin failures++; $display("[TB] FAIL wrap_base0_word: got %h expected 03000002", tx_cap[0]); end
      checks++;
      if (got_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wrap_valid: got %b expected 1", got_valid);
      end else begin
         exp = exp_q.pop_front();
         if (data1 !== exp || valid1 !== 1'b1) begin failures++; $display("[TB] FAIL wrap_data: got %h/%b expected %h/1", data1, valid1, exp); end
      end
      i_spi_ce = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_write();
      int bad_cs;
      int bad_mrdy;
      int bad_valid;
      bad_cs    = 0;
      bad_mrdy  = 0;
      bad_valid = 0;
      i_address = 12'h055;
      i_rw      = 1'b0;
      i_spi_ce  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cs_n_w[0] !== 1'b1) bad_cs++;
         if (mrdy0 !== 1'b1) bad_mrdy++;
         if (valid0 !== 1'b0) bad_valid++;
      end
      checks++;
      if (bad_cs !== 0) begin failures++; $display("[TB] FAIL write_cs_n: got %0d low samples expected 0", bad_cs); end
      checks++;
      if (bad_mrdy !== 0) begin failures++; $display("[TB] FAIL write_mrdy: got %0d low samples expected 0", bad_mrdy); end
      checks++;
      if (bad_valid !== 0) begin failures++; $display("[TB] FAIL write_valid: got %0d pulses expected 0", bad_valid); end
      i_spi_ce = 1'b0;
      i_rw     = 1'b1;
      tick();
   endtask

   task automatic test_abort();
      int         stall;
      int         cs_low;
      int         pulses;
      logic [2:0] first;
      logic       got_valid;
      logic [7:0] got_data;
      logic [7:0] exp;
      resp_byte[0] = 8'h3C;
      resp_byte[1] = 8'h3C;
      i_address    = 12'h040;
      i_rw         = 1'b1;
      i_spi_ce     = 1'b1;
      tick();
      for (int i = 0; i < 49; i++) tick();
      checks++;
      if (mrdy0 !== 1'b0 || cs_n_w[0] !== 1'b0) begin failures++; $display("[TB] FAIL abort_pre {mrdy,cs_n}: got %b%b expected 00", mrdy0, cs_n_w[0]); end
      i_reset  = 1'b0;
      i_spi_ce = 1'b0;
      tick();
      checks++;
      if (cs_n_w[0] !== 1'b1 || mrdy0 !== 1'b1 || sck_w[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_release {cs_n,mrdy,sck}: got %b%b%b expected 110", cs_n_w[0], mrdy0, sck_w[0]);
      end
      pulses = (valid0 === 1'b1) ? 1 : 0;
      i_reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (valid0 === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin failures++; $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", pulses); end
      exp_q.push_back(8'h3C);
      run_read(12'h040, 8'h3C, stall, cs_low, first, got_valid, got_data);
      checks++;
      if (stall !== EXP_STALL) begin failures++; $display("[TB] FAIL abort_later_stall: got %0d expected %0d", stall, EXP_STALL); end
      checks++;
      if (got_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_later_valid: got %b expected 1", got_valid);
      end else begin
         exp = exp_q.pop_front();
         if (got_data !== exp) begin failures++; $display("[TB] FAIL abort_later_data: got %h expected %h", got_data, exp); end
      end
      i_spi_ce = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      int         stall;
      int         cs_low;
      int         held_cs;
      int         held_valid;
      logic [2:0] first;
      logic       got_valid;
      logic [7:0] got_data;
      logic [7:0] exp;
      exp_q.push_back(8'h5A);
      run_read(12'h200, 8'h5A, stall, cs_low, first, got_valid, got_data);
      checks++;
      if (got_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_first_valid: got %b expected 1", got_valid);
      end else begin
         exp = exp_q.pop_front();
         if (got_data !== exp) begin failures++; $display("[TB] FAIL b2b_first_data: got %h expected %h", got_data, exp); end
      end
      held_cs    = 0;
      held_valid = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (cs_n_w[0] !== 1'b1 || mrdy0 !== 1'b1) held_cs++;
         if (valid0 === 1'b1) held_valid++;
      end
      checks++;
      if (held_cs !== 0 || held_valid !== 0) begin
         failures++;
         $display("[TB] FAIL b2b_held_no_retrigger: got %0d busy / %0d valid samples expected 0/0", held_cs, held_valid);
      end
      i_spi_ce = 1'b0;
      tick();
      exp_q.push_back(8'h5A);
      run_read(12'h200, 8'h5A, stall, cs_low, first, got_valid, got_data);
`ifdef SPI_FLASH_CACHE_EN
      checks++;
      if (first !== 3'b110 || stall !== 0 || cs_low !== 0) begin
         failures++;
         $display("[TB] FAIL cache_hit_timing: got first=%b stall=%0d cs_low=%0d expected 110/0/0", first, stall, cs_low);
      end
`else
      checks++;
      if (first !== 3'b000 || stall !== EXP_STALL || cs_low !== EXP_STALL) begin
         failures++;
         $display("[TB] FAIL reread_timing: got first=%b stall=%0d cs_low=%0d expected 000/%0d/%0d", first, stall, cs_low, EXP_STALL, EXP_STALL);
      end
`endif
      checks++;
      if (got_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_second_valid: got %b expected 1", got_valid);
      end else begin
         exp = exp_q.pop_front();
         if (got_data !== exp) begin failures++; $display("[TB] FAIL b2b_second_data: got %h expected %h", got_data, exp); end
      end
      i_spi_ce = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      i_reset   = 1'b0;
      i_spi_ce  = 1'b0;
      i_rw      = 1'b1;
      i_address = 12'h000;
      $display("[TB] start");
      test_reset();
      test_read();
      test_wrap();
      test_write();
      test_abort();
      test_back_to_back();
      checks++;
      if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
